uart_tx_engine: RTL and testbench
=================================

Name: uart_tx_engine

Overview:
Transmit serializer directly downstream of the TX FIFO. It pops one byte at a time from the FIFO using the FIFO's read strobe and empty flag. It then shifts the byte out on txd as an asynchronous serial frame: start, 5–8 data bits LSB first, optional parity, then 1/1.5/2 stop bits. Bit timing comes from an external 16x oversampled baud tick, and the line format matches 16550-style LCR fields.

Parameters:
OVERSAMPLE, 16, baud_tick pulses per bit period (counter width = clog2(OVERSAMPLE)+1)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
baud_tick  input  1  one-clk pulse at 16x baud rate
word_len  input  2  00=5, 01=6, 10=7, 11=8 data bits
stop_bits  input  1  0=1 stop; 1=2 stop (1.5 when word_len=00)
parity_en  input  1  parity bit inserted when 1
even_parity  input  1  1=even, 0=odd
stick_parity  input  1  parity bit forced to ~even_parity
break_ctrl  input  1  force txd low while 1
tx_data_in  input  8  FIFO head byte, combinational and valid whenever txff_empty=0
txff_empty  input  1  FIFO empty flag
tx_rd  output  1  one-clk pop strobe to FIFO
txd  output  1  serial line, idle high
tx_busy  output  1  frame in progress (any state but IDLE)
tsr_empty  output  1  high when IDLE and txff_empty=1 (TEMT)

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- Reset values: txd=1, tx_rd=0, tx_busy=0, tsr_empty=1, state=IDLE, all counters 0.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If txff_empty=0, assert tx_rd for exactly one clk.
  - In the same edge, latch tx_data_in into the shift reg and latch all format inputs into a config reg.
  - Go to START and clear the tick counter.
  - Format input changes mid-frame have no effect.
- Bit period:
  - Each state holds for OVERSAMPLE baud_ticks, counted from state entry.
  - Transition occurs on the clk edge that samples the 16th tick.
  - Clk cycles between ticks are not counted.
- START: txd=0.
- DATA:
  - txd = shift_reg[0]; shift right at the end of each bit.
  - Bit counter runs 0..N-1, N = 5 + word_len.
  - After bit N-1, go to PARITY if parity_en, else STOP.
- PARITY:
  - Normal: txd = XOR of the N latched data bits, inverted when even_parity=0.
  - Stick: txd = ~even_parity.
- STOP:
  - txd=1.
  - Length is 16 ticks (1 stop), 32 ticks (2 stop), or 24 ticks (1.5 stop when word_len=00 and stop_bits=1).
- End of STOP:
  - If txff_empty=0, pop (tx_rd pulse) on that same edge and go directly to START, with no idle bit between frames.
  - Otherwise go to IDLE.
- tx_rd never asserts outside IDLE or the final STOP edge, and never when txff_empty=1.
- break_ctrl: txd is forced to 0 combinationally after the state-driven value; the FSM keeps running unaffected.
- tx_busy and tsr_empty are registered from next-state, so they update on the same edge as the state.
- Reset mid-frame: txd returns high asynchronously, the frame is abandoned, and no pop is issued. The FIFO reset is independent.
- baud_tick asserting continuously (every clk) is legal and gives a 16-clk bit period.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE/START/DATA/PARITY/STOP)
  - word_len encodings (WL5..WL8)
  - OVERSAMPLE default
  - STOP_TICKS_1/1P5/2 constants (16/24/32)
- One sub-module is natural: uart_bit_timer. It counts baud_ticks against a loaded terminal count and outputs bit_done. It is shared later by the RX side.

Test Plan:
- 8N1, baud_tick every 4 clk, FIFO holds 0x55 → one tx_rd pulse. txd = 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), each bit 64 clk. Frame is 640 clk, then tsr_empty=1.
- 7E1, byte 0x41 → 7 data bits 1000001 LSB first, parity 0. Repeat 7O1 → parity 1. With stick_parity=1, even_parity=1 → parity 0.
- 5-bit, stop_bits=1, byte 0x1F → data 11111, stop high for exactly 24 ticks. 8N2 → stop high for 32 ticks.
- FIFO holds 0xA5 then 0x3C, 8N1 → second tx_rd on the last-stop edge. Start bit of 0x3C follows immediately with no gap, and tx_busy stays 1 throughout.
- break_ctrl=1 during a DATA bit of 0xFF → txd=0 while asserted. Release → frame resumes at the correct bit, and total frame length is unchanged.
- reset_n low at DATA bit 3 → txd=1, tx_busy=0 asynchronously. After release with txff_empty=1: no tx_rd, tsr_empty=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants: FSM states, LCR word-length codes and
// stop-bit durations, plus helpers for data masking and parity generation.
package uart_pkg;

   localparam int DEFAULT_OVERSAMPLE = 16;

   // Stop durations in baud ticks at the default oversampling rate
   localparam int STOP_TICKS_1   = 16;
   localparam int STOP_TICKS_1P5 = 24;
   localparam int STOP_TICKS_2   = 32;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } txState_e;

   typedef enum logic [1:0] {
      WL5 = 2'b00,
      WL6 = 2'b01,
      WL7 = 2'b10,
      WL8 = 2'b11
   } wordLen_e;

   typedef struct packed {
      wordLen_e wordLen;
      logic     stopBits;
      logic     parityEn;
   } txCfg_t;

   function automatic logic [7:0] dataMask(input wordLen_e wl);
      logic [7:0] mask;
      case (wl)
         WL5:     mask = 8'h1F;
         WL6:     mask = 8'h3F;
         WL7:     mask = 8'h7F;
         default: mask = 8'hFF;
      endcase
      return mask;
   endfunction

   // Even parity drives the XOR of the data bits; odd inverts it; stick
   // parity ignores the data and sends the complement of the even select.
   function automatic logic calcParity(input logic [7:0] data,
                                       input wordLen_e   wl,
                                       input logic       evenSel,
                                       input logic       stickSel);
      logic p;
      p = ^(data & dataMask(wl));
      if (stickSel) begin
         return ~evenSel;
      end
      return evenSel ? p : ~p;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Counts baud ticks from a cleared start and flags the tick that completes
// a bit period of (lastCount_i + 1) ticks; the counter wraps on that tick.
module uart_bit_timer #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear_i,
   input  logic             tick_i,
   input  logic [WIDTH-1:0] lastCount_i,
   output logic             bitDone_o
);

   logic [WIDTH-1:0] countQ;
   logic [WIDTH-1:0] countD;

   assign bitDone_o = tick_i & ~clear_i & (countQ == lastCount_i);

   always_comb begin
      countD = countQ;
      if (clear_i) begin
         countD = '0;
      end else if (tick_i) begin
         countD = bitDone_o ? '0 : countQ + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         countQ <= '0;
      end else begin
         countQ <= countD;
      end
   end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit serializer: pops bytes from the TX FIFO and shifts out
// start, 5-8 data bits LSB first, optional parity and 1/1.5/2 stop bits.
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       baud_tick,
   input  logic [1:0] word_len,
   input  logic       stop_bits,
   input  logic       parity_en,
   input  logic       even_parity,
   input  logic       stick_parity,
   input  logic       break_ctrl,
   input  logic [7:0] tx_data_in,
   input  logic       txff_empty,
   output logic       tx_rd,
   output logic       txd,
   output logic       tx_busy,
   output logic       tsr_empty
);

   localparam int CNT_W     = $clog2(OVERSAMPLE) + 1;
   localparam int TICKS_1   = STOP_TICKS_1   * OVERSAMPLE / DEFAULT_OVERSAMPLE;
   localparam int TICKS_1P5 = STOP_TICKS_1P5 * OVERSAMPLE / DEFAULT_OVERSAMPLE;
   localparam int TICKS_2   = STOP_TICKS_2   * OVERSAMPLE / DEFAULT_OVERSAMPLE;

   localparam logic [CNT_W-1:0] LAST_BIT_TICK = CNT_W'(OVERSAMPLE - 1);
   localparam logic [CNT_W-1:0] LAST_STOP_1   = CNT_W'(TICKS_1 - 1);
   localparam logic [CNT_W-1:0] LAST_STOP_1P5 = CNT_W'(TICKS_1P5 - 1);
   localparam logic [CNT_W-1:0] LAST_STOP_2   = CNT_W'(TICKS_2 - 1);

   txState_e   stateQ, stateD;
   logic [7:0] shiftQ, shiftD;
   logic [2:0] bitCntQ, bitCntD;
   txCfg_t     cfgQ, cfgD;
   logic       parityQ, parityD;
   logic       txdQ, txdD;
   logic       busyQ;
   logic       tsrEmptyQ;

   logic             popReq;
   logic             bitDone;
   logic             timerClear;
   logic [CNT_W-1:0] lastCount;
   logic [2:0]       lastDataBit;

   assign lastDataBit = 3'd4 + {1'b0, cfgQ.wordLen};
   assign timerClear  = (stateQ == IDLE);

   // Only the stop period varies in length; 1.5 stop exists only for 5-bit words
   always_comb begin
      lastCount = LAST_BIT_TICK;
      if (stateQ == STOP) begin
         if (!cfgQ.stopBits) begin
            lastCount = LAST_STOP_1;
         end else if (cfgQ.wordLen == WL5) begin
            lastCount = LAST_STOP_1P5;
         end else begin
            lastCount = LAST_STOP_2;
         end
      end
   end

   uart_bit_timer #(
      .WIDTH (CNT_W)
   ) u_bitTimer (
      .clk         (clk),
      .reset_n     (reset_n),
      .clear_i     (timerClear),
      .tick_i      (baud_tick),
      .lastCount_i (lastCount),
      .bitDone_o   (bitDone)
   );

   always_comb begin
      stateD  = stateQ;
      shiftD  = shiftQ;
      bitCntD = bitCntQ;
      cfgD    = cfgQ;
      parityD = parityQ;
      popReq  = 1'b0;

      case (stateQ)
         IDLE: begin
            popReq = ~txff_empty;
         end
         START: begin
            if (bitDone) begin
               stateD = DATA;
            end
         end
         DATA: begin
            if (bitDone) begin
               shiftD  = {1'b0, shiftQ[7:1]};
               bitCntD = bitCntQ + 3'd1;
               if (bitCntQ == lastDataBit) begin
                  bitCntD = '0;
                  stateD  = cfgQ.parityEn ? PARITY : STOP;
               end
            end
         end
         PARITY: begin
            if (bitDone) begin
               stateD = STOP;
            end
         end
         STOP: begin
            if (bitDone) begin
               popReq = ~txff_empty;
               stateD = IDLE;
            end
         end
         default: begin
            stateD = IDLE;
         end
      endcase

      // A pop always starts a new frame, whether from IDLE or back-to-back from STOP
      if (popReq) begin
         stateD  = START;
         bitCntD = '0;
         shiftD  = tx_data_in;
         cfgD    = '{wordLen: wordLen_e'(word_len), stopBits: stop_bits, parityEn: parity_en};
         parityD = calcParity(tx_data_in, wordLen_e'(word_len), even_parity, stick_parity);
      end

      case (stateD)
         START:   txdD = 1'b0;
         DATA:    txdD = shiftD[0];
         PARITY:  txdD = parityD;
         default: txdD = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stateQ    <= IDLE;
         shiftQ    <= '0;
         bitCntQ   <= '0;
         cfgQ      <= '0;
         parityQ   <= 1'b0;
         txdQ      <= 1'b1;
         busyQ     <= 1'b0;
         tsrEmptyQ <= 1'b1;
      end else begin
         stateQ    <= stateD;
         shiftQ    <= shiftD;
         bitCntQ   <= bitCntD;
         cfgQ      <= cfgD;
         parityQ   <= parityD;
         txdQ      <= txdD;
         busyQ     <= (stateD != IDLE);
         tsrEmptyQ <= (stateD == IDLE) & txff_empty;
      end
   end

   // Gating with reset_n keeps the FIFO untouched while the engine is held in reset
   assign tx_rd     = popReq & reset_n;
   assign txd       = txdQ & ~break_ctrl;
   assign tx_busy   = busyQ;
   assign tsr_empty = tsrEmptyQ;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: a FIFO/baud-tick driver feeds bytes, a scoreboard
// holds the frame expected for each byte and bit-centre sampling checks it.
module tb_uart_tx_engine;

   typedef struct {
      logic [7:0] data;
      int         nBits;
      bit         parEn;
      logic       parBit;
      int         stopClks;
      int         bitClks;
   } frameExp_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       baud_tick;
   logic [1:0] word_len;
   logic       stop_bits;
   logic       parity_en;
   logic       even_parity;
   logic       stick_parity;
   logic       break_ctrl;
   logic [7:0] tx_data_in;
   logic       txff_empty;
   logic       tx_rd;
   logic       txd;
   logic       tx_busy;
   logic       tsr_empty;

   int total    = 0;
   int bad      = 0;
   int cyc      = 0;
   int tickDiv  = 4;
   int tickPh   = 0;
   int popCount = 0;
   int expPops  = 0;
   bit popPending = 1'b0;

   logic [7:0] fifoQ[$];
   logic [7:0] pendQ[$];
   int         popCycQ[$];
   int         stopEndQ[$];
   frameExp_t  expQ[$];

   uart_tx_engine #(
      .OVERSAMPLE (16)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .baud_tick    (baud_tick),
      .word_len     (word_len),
      .stop_bits    (stop_bits),
      .parity_en    (parity_en),
      .even_parity  (even_parity),
      .stick_parity (stick_parity),
      .break_ctrl   (break_ctrl),
      .tx_data_in   (tx_data_in),
      .txff_empty   (txff_empty),
      .tx_rd        (tx_rd),
      .txd          (txd),
      .tx_busy      (tx_busy),
      .tsr_empty    (tsr_empty)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic nextSample();
      @(negedge clk);
      #2;
   endtask

   // Drives baud_tick and the FIFO model; bytes enter the FIFO only on a tick
   // cycle so every start bit lasts a full bit period.
   initial begin
      baud_tick  = 1'b0;
      txff_empty = 1'b1;
      tx_data_in = 8'h00;
      forever begin
         @(negedge clk);
         cyc++;
         if (popPending) begin
            if (fifoQ.size() > 0) void'(fifoQ.pop_front());
            popPending = 1'b0;
         end
         baud_tick = (tickPh == 0);
         tickPh    = (tickPh + 1 >= tickDiv) ? 0 : tickPh + 1;
         if (baud_tick && pendQ.size() > 0) begin
            foreach (pendQ[k]) fifoQ.push_back(pendQ[k]);
            pendQ.delete();
         end
         txff_empty = (fifoQ.size() == 0);
         tx_data_in = txff_empty ? 8'h00 : fifoQ[0];
         #1;
         if (tx_rd === 1'b1) begin
            popCount++;
            popCycQ.push_back(cyc);
            popPending = 1'b1;
            checkOutput("rdNotEmpty", 32'(txff_empty), 0);
         end
      end
   end

   task automatic setFormat(input logic [1:0] wl, input logic sb, input logic pe,
                            input logic ev, input logic st);
      word_len     = wl;
      stop_bits    = sb;
      parity_en    = pe;
      even_parity  = ev;
      stick_parity = st;
   endtask

   task automatic applyStimulus(input logic [7:0] d, input bit scored);
      frameExp_t e;
      logic      p;
      int        n;
      n = 5 + int'(word_len);
      p = 1'b0;
      for (int k = 0; k < n; k++) p = p ^ d[k];
      e.nBits    = n;
      e.data     = d & (8'hFF >> (8 - n));
      e.parEn    = parity_en;
      e.parBit   = stick_parity ? ~even_parity : (even_parity ? p : ~p);
      e.stopClks = (stop_bits ? ((word_len == 2'b00) ? 24 : 32) : 16) * tickDiv;
      e.bitClks  = 16 * tickDiv;
      if (scored) expQ.push_back(e);
      pendQ.push_back(d);
      expPops++;
   endtask

   task automatic checkFrame(input string tag);
      frameExp_t  e;
      int         w, off, last, stopCnt, busyLow, target, lastCyc, bClk;
      logic [7:0] got;
      logic       bitVal;
      if (expQ.size() == 0) begin
         checkOutput({tag, ".sbEmpty"}, 1, 0);
         return;
      end
      e    = expQ.pop_front();
      bClk = e.bitClks;
      w    = 0;
      while (txd !== 1'b0 && w < 20000) begin
         nextSample();
         w++;
      end
      checkOutput({tag, ".startSeen"}, 32'(w < 20000), 1);
      if (w >= 20000) return;
      last    = e.nBits + (e.parEn ? 1 : 0);
      off     = 0;
      busyLow = 0;
      got     = 8'h00;
      for (int i = 0; i <= last; i++) begin
         target = i * bClk + bClk / 2;
         while (off < target) begin
            nextSample();
            off++;
            if (tx_busy !== 1'b1) busyLow++;
         end
         bitVal = txd;
         if (i == 0) checkOutput({tag, ".startBit"}, 32'(bitVal), 0);
         else if (i <= e.nBits) got[i-1] = bitVal;
         else checkOutput({tag, ".parity"}, 32'(bitVal), 32'(e.parBit));
      end
      checkOutput({tag, ".data"}, 32'(got), 32'(e.data));
      while (off < (last + 1) * bClk) begin
         nextSample();
         off++;
         if (tx_busy !== 1'b1) busyLow++;
      end
      checkOutput({tag, ".busyHeld"}, busyLow, 0);
      stopCnt = 0;
      lastCyc = cyc;
      while (txd === 1'b1 && tx_busy === 1'b1 && stopCnt < e.stopClks + 200) begin
         lastCyc = cyc;
         stopCnt++;
         nextSample();
      end
      checkOutput({tag, ".stopClks"}, stopCnt, e.stopClks);
      stopEndQ.push_back(lastCyc);
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, ".busyLow"}, 32'(tx_busy), 0);
      checkOutput({tag, ".temt"}, 32'(tsr_empty), 1);
      checkOutput({tag, ".pops"}, popCount, expPops);
   endtask

   // Breaks txd in the back half of data bit 3 and scrambles the format
   // inputs, neither of which may disturb the frame being sent.
   task automatic breakPulse();
      int w, bClk;
      bClk = 16 * tickDiv;
      w    = 0;
      while (txd !== 1'b0 && w < 20000) begin
         nextSample();
         w++;
      end
      word_len  = 2'b00;
      parity_en = 1'b1;
      repeat (4 * bClk + bClk / 2 + 2) nextSample();
      break_ctrl = 1'b1;
      #1 checkOutput("brk.txdLow", 32'(txd), 0);
      repeat (3) nextSample();
      checkOutput("brk.txdHeld", 32'(txd), 0);
      break_ctrl = 1'b0;
      #1 checkOutput("brk.txdResume", 32'(txd), 1);
   endtask

   initial begin
      int base, w, lowCnt, bClk;
      reset_n    = 1'b0;
      break_ctrl = 1'b0;
      setFormat(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) nextSample();
      checkOutput("rst.txd", 32'(txd), 1);
      checkOutput("rst.txRd", 32'(tx_rd), 0);
      checkOutput("rst.busy", 32'(tx_busy), 0);
      checkOutput("rst.temt", 32'(tsr_empty), 1);
      reset_n = 1'b1;
      repeat (5) nextSample();

      applyStimulus(8'h55, 1'b1);
      checkFrame("8N1");
      checkIdle("8N1");

      setFormat(2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(8'h41, 1'b1);
      checkFrame("7E1");
      setFormat(2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(8'h41, 1'b1);
      checkFrame("7O1");
      setFormat(2'b10, 1'b0, 1'b1, 1'b1, 1'b1);
      applyStimulus(8'h41, 1'b1);
      checkFrame("7S1");
      setFormat(2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
      applyStimulus(8'h00, 1'b1);
      checkFrame("8M1");

      setFormat(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(8'h1F, 1'b1);
      checkFrame("5N1p5");
      setFormat(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(8'h96, 1'b1);
      checkFrame("8N2");
      checkIdle("stops");

      setFormat(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      base = popCycQ.size();
      applyStimulus(8'hA5, 1'b1);
      applyStimulus(8'h3C, 1'b1);
      checkFrame("b2b.first");
      checkFrame("b2b.second");
      checkOutput("b2b.popCount", popCycQ.size() - base, 2);
      if (popCycQ.size() >= base + 2 && stopEndQ.size() >= 2)
         checkOutput("b2b.popEdge", popCycQ[base+1], stopEndQ[stopEndQ.size()-2]);
      checkIdle("b2b");

      applyStimulus(8'hFF, 1'b1);
      fork
         checkFrame("brk");
         breakPulse();
      join
      setFormat(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      checkIdle("brk");

      tickDiv = 1;
      repeat (4) nextSample();
      setFormat(2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(8'h5A, 1'b1);
      checkFrame("fastTick");
      checkIdle("fastTick");

      tickDiv = 4;
      repeat (8) nextSample();
      setFormat(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      bClk = 16 * tickDiv;
      applyStimulus(8'hC3, 1'b0);
      w = 0;
      while (txd !== 1'b0 && w < 20000) begin
         nextSample();
         w++;
      end
      checkOutput("rstMid.startSeen", 32'(w < 20000), 1);
      repeat (4 * bClk + bClk / 2) nextSample();
      reset_n = 1'b0;
      #1;
      checkOutput("rstMid.txd", 32'(txd), 1);
      checkOutput("rstMid.busy", 32'(tx_busy), 0);
      repeat (3) nextSample();
      reset_n = 1'b1;
      lowCnt = 0;
      repeat (300) begin
         nextSample();
         if (txd !== 1'b1) lowCnt++;
      end
      checkOutput("rstMid.lineIdle", lowCnt, 0);
      checkIdle("rstMid");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
